controlador_generador: RTL
==========================

# controlador_generador

Sequencer for the 8f-derived clock generation path. Runs on `clk_8f` and produces phase-aligned one-cycle enable strobes at 4f, 2f and f rates, gated by a start/stop handshake, a programmable settling interval and a lock indication. Downstream serialisers and paralellisers use these enables instead of sampling divided clocks directly. A stop request always completes the current f period, so the f-rate word boundary is never truncated.

## Interface
- `DELAY_CYCLES`, default 4: number of `clk_8f` cycles spent in ARM before RUN; legal range 1..15.
- `clk_8f` in 1: sole clock; all flops use its rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `start` in 1: level request to begin generation; sampled in IDLE only.
- `stop` in 1: level request to end generation; sampled in ARM and RUN.
- `en_4f` out 1: one-cycle strobe, every 2nd cycle.
- `en_2f` out 1: one-cycle strobe, every 4th cycle.
- `en_f` out 1: one-cycle strobe, every 8th cycle.
- `fase` out 3: current phase counter `cnt`.
- `lock` out 1: high in RUN and DRAIN.
- `estado` out 2: FSM state encoding, for debug.

## Operation
- All outputs are registered. Reset values: `en_4f=0`, `en_2f=0`, `en_f=0`, `fase=0`, `lock=0`, `estado=IDLE`.
- States and encoding: IDLE=00, ARM=01, RUN=10, DRAIN=11.
- **IDLE**
  - `cnt` held at 0; no strobes.
  - `start=1` -> ARM, with the settle counter loaded to `DELAY_CYCLES-1`.
  - `stop` is ignored; `start` and `stop` both high -> ARM.
- **ARM**
  - Settle counter decrements once per cycle.
  - `stop=1` -> IDLE on the next cycle; stop has priority over expiry.
  - Counter at 0 with `stop=0` -> RUN, with `cnt=0`.
- **RUN**
  - `cnt` increments mod 8 every cycle.
  - Strobe decode:
    - `en_4f = cnt[0]`
    - `en_2f = (cnt[1:0]==3)`
    - `en_f = (cnt==7)`
  - `stop=1` -> DRAIN; `start` is ignored.
- **DRAIN**
  - `cnt` and strobes continue exactly as in RUN.
  - After the cycle with `cnt==7` (`en_f` high) -> IDLE with `cnt=0`.
  - If `stop` is sampled while `cnt==7`, that same cycle is the final one: RUN goes directly to IDLE.
  - `start` is ignored.
- `cnt` wrap-around 7->0 is silent in RUN.
- Reset asserted mid-operation, in any state, returns to IDLE asynchronously and drops all strobes in the same cycle. There is no partial-period completion on reset.
- Settle counter width: 4 bits.

## Timing
- `start` high at edge k in IDLE:
  - ARM during cycles k+1 .. k+DELAY_CYCLES.
  - RUN from cycle k+DELAY_CYCLES+1; `lock=1` from that cycle.
- Relative to RUN entry at cycle r, with `fase=0` at r:
  - First `en_4f` at r+1.
  - First `en_2f` at r+3.
  - First `en_f` at r+7.
  - Steady-state periods: 2, 4 and 8 cycles.
- Every `en_2f` coincides with an `en_4f`, and every `en_f` coincides with both.
- `stop` sampled in RUN at a cycle with `fase=p`: last strobe cycle is the next `fase==7`; IDLE and `lock=0` on the following cycle. Drain length is (7-p) cycles after the sampling cycle.
- Minimum restart gap: `start` is accepted on the first IDLE cycle.

## Configuration
- `CTRL_GEN_SYNC_EN` defined:
  - `start` and `stop` each pass through a two-flop synchroniser before the FSM, adding 2 cycles of request latency.
  - Synchroniser flops reset to 0.
- Undefined: inputs go straight to the FSM, which is valid only for requesters already in `clk_8f`.

## Structure
- Package `gen_ctrl_pkg` contains:
  - State encoding constants IDLE/ARM/RUN/DRAIN.
  - Phase constants `FASE_ULT=3'd7` and `FASE_2F_MASK=2'b11`.
  - Settle counter width constant (4).
- Sub-module `sincronizador_2ff` (1-bit, async active-low reset), instantiated twice only under `CTRL_GEN_SYNC_EN`.

## Test plan
- Reset, then `start` pulsed for 1 cycle with `DELAY_CYCLES=4` -> ARM for 4 cycles, then `lock=1`. `en_4f` at RUN+1,3,5,7; `en_2f` at +3,+7; `en_f` at +7, then every 8 cycles.
- `stop` raised in RUN at `fase=2` -> strobes continue through `fase=7` (`en_f=1`), then IDLE, `lock=0`, `fase=0`.
- `stop` raised in ARM on its 2nd cycle -> IDLE the next cycle; no strobe ever asserted.
- `start` and `stop` both high in IDLE -> ARM; `stop` still high at ARM -> IDLE on the following cycle.
- `reset` driven to 0 while `fase=5` in RUN -> all outputs 0 immediately, before the next clock edge; `start` after release -> normal ARM sequence.
- With `CTRL_GEN_SYNC_EN`: `start` at edge k -> ARM entered at k+3 and `lock` rises at k+3+DELAY_CYCLES.

Source files
------------

// File: rtl/gen_ctrl_pkg.sv
// rtl/gen_ctrl_pkg.sv - shared state encoding and phase constants for the 8f enable sequencer
package gen_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARM   = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } estado_t;

  // Last phase of an f period; en_f fires here and DRAIN exits after it
  localparam logic [2:0] FASE_ULT     = 3'd7;
  // Low phase bits that mark an en_2f cycle
  localparam logic [1:0] FASE_2F_MASK = 2'b11;
  // Width of the ARM settle counter (DELAY_CYCLES up to 15)
  localparam int         SETTLE_W     = 4;

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop single-bit synchroniser into clk_8f
module sincronizador_2ff (
  input  logic clk_8f,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear to 0 so no spurious request follows reset
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controlador_generador.sv
// rtl/controlador_generador.sv - 4f/2f/f enable sequencer with settle, lock and drain (CTRL_GEN_SYNC_EN adds input synchronisers)
module controlador_generador
  import gen_ctrl_pkg::*;
#(
  parameter int DELAY_CYCLES = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  output logic       en_4f,
  output logic       en_2f,
  output logic       en_f,
  output logic [2:0] fase,
  output logic       lock,
  output logic [1:0] estado
);

  localparam logic [SETTLE_W-1:0] SETTLE_INI = SETTLE_W'(DELAY_CYCLES - 1);

  logic                start_s;
  logic                stop_s;
  estado_t             state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic [SETTLE_W-1:0] settle, settle_n;
  logic                activo_n;
  logic                en_4f_n, en_2f_n, en_f_n;

`ifdef CTRL_GEN_SYNC_EN
  sincronizador_2ff u_sync_start (
    .clk_8f (clk_8f),
    .reset  (reset),
    .d      (start),
    .q      (start_s)
  );

  sincronizador_2ff u_sync_stop (
    .clk_8f (clk_8f),
    .reset  (reset),
    .d      (stop),
    .q      (stop_s)
  );
`else
  assign start_s = start;
  assign stop_s  = stop;
`endif

  // Next state, phase and settle count; a stop in RUN only ends at the f boundary
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    settle_n = settle;
    unique case (state)
      IDLE: begin
        cnt_n = 3'd0;
        if (start_s) begin
          state_n  = ARM;
          settle_n = SETTLE_INI;
        end
      end
      ARM: begin
        cnt_n = 3'd0;
        if (stop_s) begin
          state_n = IDLE;
        end else if (settle == '0) begin
          state_n = RUN;
        end else begin
          settle_n = settle - 1'b1;
        end
      end
      RUN: begin
        cnt_n = cnt + 3'd1;
        if (stop_s) begin
          if (cnt == FASE_ULT) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
          end else begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        cnt_n = cnt + 3'd1;
        if (cnt == FASE_ULT) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  // Strobes decoded from the upcoming phase so the registered outputs line up with fase
  always_comb begin
    activo_n = (state_n == RUN) || (state_n == DRAIN);
    en_4f_n  = activo_n && cnt_n[0];
    en_2f_n  = activo_n && (cnt_n[1:0] == FASE_2F_MASK);
    en_f_n   = activo_n && (cnt_n == FASE_ULT);
  end

  // State, phase, settle and output registers; reset drops every strobe at once
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      settle <= '0;
      en_4f  <= 1'b0;
      en_2f  <= 1'b0;
      en_f   <= 1'b0;
      lock   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      settle <= settle_n;
      en_4f  <= en_4f_n;
      en_2f  <= en_2f_n;
      en_f   <= en_f_n;
      lock   <= activo_n;
    end
  end

  assign fase   = cnt;
  assign estado = state;

endmodule
